multicycle_control: RTL and testbench

Parametrised multi-cycle successor to the single-cycle opcode decoder. An FSM sequences each instruction through fetch, decode, execute, memory and writeback, and handshakes with a shared instruction/data memory via mem_ready. Beyond the single-cycle decoder it adds:
- ADDI and HALT opcodes
- illegal-opcode and memory-timeout traps
- a global stall input
- a retired-instruction counter

It sits between the IR/datapath and the shared memory port.

---
 rtl/multicycle_pkg.sv | 49 ++++
 rtl/multicycle_control_mem_wait_timer.sv | 37 +++
 rtl/multicycle_control.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle control unit:
// FSM states, opcodes, ALU operations and trap causes.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'h0,
        S_FETCH    = 4'h1,
        S_DECODE   = 4'h2,
        S_EXEC     = 4'h3,
        S_ALU_WB   = 4'h4,
        S_MEM_ADDR = 4'h5,
        S_MEM_ACC  = 4'h6,
        S_MEM_WB   = 4'h7,
        S_BRANCH   = 4'h8,
        S_JUMP     = 4'h9,
        S_HALT     = 4'hA,
        S_TRAP     = 4'hB
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_LW   = 4'h4;
    localparam logic [3:0] OP_SW   = 4'h5;
    localparam logic [3:0] OP_BEQ  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    function automatic logic [1:0] alu_of(input logic [3:0] op);
        unique case (op)
            OP_SUB:  alu_of = ALU_SUB;
            OP_AND:  alu_of = ALU_AND;
            OP_OR:   alu_of = ALU_OR;
            default: alu_of = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts consecutive enabled cycles spent waiting on mem_ready and
// flags the cycle on which the wait budget runs out.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic waiting,
    input  logic mem_ready,
    output logic timeout
);

    generate
        if (MEM_TIMEOUT == 0) begin : g_off
            logic unused_in;
            assign unused_in = &{1'b0, clk, rst_n, en, waiting, mem_ready};
            assign timeout   = 1'b0;
        end else begin : g_on
            localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
            logic [W-1:0] count;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    count <= '0;
                end else if (en) begin
                    if (waiting && !mem_ready) count <= count + W'(1);
                    else                       count <= '0;
                end
            end

            assign timeout = waiting && !mem_ready &&
                             (count == W'(MEM_TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback
// sequencing with traps, halt, stall and a retire counter.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src,
    output logic [1:0]          alu_op,
    output logic                branch,
    output logic                jump,
    output logic                halted,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [CNT_W-1:0]    instr_count,
    output logic [3:0]          state
);

    state_t           state_q, state_n;
    logic [1:0]       cause_q, cause_n;
    logic [CNT_W-1:0] count_q;
    logic             retire;
    logic             timeout;

    logic [3:0] op;
    logic       op_hi, legal;
    logic       is_alu, is_addi, is_lw, is_sw;

    assign op      = opcode[3:0];
    assign op_hi   = (opcode >> 4) != '0;
    assign legal   = !op_hi && (op <= OP_ADDI || op == OP_HALT);
    assign is_addi = legal && op == OP_ADDI;
    assign is_alu  = legal && (op <= OP_OR || op == OP_ADDI);
    assign is_lw   = legal && op == OP_LW;
    assign is_sw   = legal && op == OP_SW;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .waiting   (state_q == S_FETCH || state_q == S_MEM_ACC),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cause_q <= CAUSE_NONE;
            count_q <= '0;
        end else if (en) begin
            state_q <= state_n;
            cause_q <= cause_n;
            if (retire) count_q <= count_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_n = state_q;
        cause_n = cause_q;
        retire  = 1'b0;
        unique case (state_q)
            S_IDLE: state_n = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_n = S_DECODE;
                end else if (timeout) begin
                    state_n = S_TRAP;
                    cause_n = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    state_n = S_TRAP;
                    cause_n = CAUSE_ILLEGAL;
                end else if (is_alu) begin
                    state_n = S_EXEC;
                end else if (is_lw || is_sw) begin
                    state_n = S_MEM_ADDR;
                end else if (op == OP_BEQ) begin
                    state_n = S_BRANCH;
                end else if (op == OP_JMP) begin
                    state_n = S_JUMP;
                end else begin
                    state_n = S_HALT;
                    retire  = 1'b1;
                end
            end
            S_EXEC:     state_n = S_ALU_WB;
            S_MEM_ADDR: state_n = S_MEM_ACC;
            S_MEM_ACC: begin
                if (mem_ready) begin
                    if (is_lw) begin
                        state_n = S_MEM_WB;
                    end else begin
                        state_n = S_FETCH;
                        retire  = 1'b1;
                    end
                end else if (timeout) begin
                    state_n = S_TRAP;
                    cause_n = CAUSE_TIMEOUT;
                end
            end
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: begin
                state_n = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT, S_TRAP: state_n = state_q;
            default:        state_n = S_IDLE;
        endcase
    end

    always_comb begin
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src       = 1'b0;
        alu_op        = ALU_ADD;
        branch        = 1'b0;
        jump          = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read = !timeout;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_EXEC: begin
                alu_op  = alu_of(op);
                alu_src = is_addi;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = !is_addi;
                alu_op    = alu_of(op);
                alu_src   = is_addi;
            end
            S_MEM_ADDR: alu_src = 1'b1;
            S_MEM_ACC: begin
                iord      = 1'b1;
                mem_read  = is_lw && !timeout;
                mem_write = is_sw && !timeout;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                alu_op        = ALU_SUB;
                branch        = 1'b1;
                pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                jump     = 1'b1;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        // A stalled cycle must not disturb memory, IR, PC or registers.
        if (!en) begin
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            reg_write     = 1'b0;
        end
    end

    assign halted      = state_q == S_HALT;
    assign trap        = state_q == S_TRAP;
    assign trap_cause  = cause_q;
    assign instr_count = count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control (OPCODE_W=6, CNT_W=4,
// MEM_TIMEOUT=8) driven by hand-computed per-cycle expectations.
module tb_multicycle_control;

    localparam int OW = 6;
    localparam int CW = 4;

    localparam logic [3:0] S_IDLE = 4'h0, S_FETCH = 4'h1, S_DECODE = 4'h2;
    localparam logic [3:0] S_EXEC = 4'h3, S_ALU_WB = 4'h4, S_MADDR = 4'h5;
    localparam logic [3:0] S_MACC = 4'h6, S_MWB = 4'h7, S_BRANCH = 4'h8;
    localparam logic [3:0] S_JUMP = 4'h9, S_HALT = 4'hA, S_TRAP = 4'hB;

    localparam logic [OW-1:0] O_ADD = 6'h00, O_SUB = 6'h01, O_AND = 6'h02;
    localparam logic [OW-1:0] O_OR = 6'h03, O_LW = 6'h04, O_SW = 6'h05;
    localparam logic [OW-1:0] O_BEQ = 6'h06, O_JMP = 6'h07, O_ADDI = 6'h08;
    localparam logic [OW-1:0] O_HALT = 6'h0F, O_ILL_C = 6'h0C;
    localparam logic [OW-1:0] O_ILL_HI = 6'h10;

    localparam logic [17:0] IORD = 18'h20000, MRD = 18'h10000;
    localparam logic [17:0] MWR = 18'h08000, IRW = 18'h04000;
    localparam logic [17:0] PCW = 18'h02000, PCC = 18'h01000;
    localparam logic [17:0] RW = 18'h00800, RDST = 18'h00400;
    localparam logic [17:0] M2R = 18'h00200, ASRC = 18'h00100;
    localparam logic [17:0] A_SUB = 18'h00040, A_AND = 18'h00080;
    localparam logic [17:0] A_OR = 18'h000C0, BR = 18'h00020;
    localparam logic [17:0] JMP = 18'h00010, HLT = 18'h00008;
    localparam logic [17:0] TRP = 18'h00004, TC_TMO = 18'h00002;
    localparam logic [17:0] TC_ILL = 18'h00001;
    localparam logic [17:0] F_RDY = MRD | IRW | PCW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          mem_ready = 1'b0;
    logic [OW-1:0] opcode = '0;

    logic          iord, mem_read, mem_write, ir_write, pc_write;
    logic          pc_write_cond, reg_write, reg_dst, mem_to_reg, alu_src;
    logic [1:0]    alu_op, trap_cause;
    logic          branch, jump, halted, trap;
    logic [CW-1:0] instr_count;
    logic [3:0]    state;
    logic [17:0]   ctl_act;

    multicycle_control #(
        .OPCODE_W(OW), .CNT_W(CW), .MEM_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode),
        .mem_ready(mem_ready), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
        .alu_op(alu_op), .branch(branch), .jump(jump), .halted(halted),
        .trap(trap), .trap_cause(trap_cause), .instr_count(instr_count),
        .state(state)
    );

    assign ctl_act = {iord, mem_read, mem_write, ir_write, pc_write,
                      pc_write_cond, reg_write, reg_dst, mem_to_reg,
                      alu_src, alu_op, branch, jump, halted, trap,
                      trap_cause};

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    st;
        logic [17:0]   ctl;
        logic [CW-1:0] cnt;
        string         nm;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    // Monitor: one expectation per driven cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            tests++;
            if (state !== mon_e.st || ctl_act !== mon_e.ctl ||
                instr_count !== mon_e.cnt) begin
                fails++;
                $display("FAIL %s: got state=%h ctl=%b cnt=%0d, want state=%h ctl=%b cnt=%0d",
                         mon_e.nm, state, ctl_act, instr_count,
                         mon_e.st, mon_e.ctl, mon_e.cnt);
            end
        end
    end

    task automatic step(input logic r, input logic e_i, input logic rdy,
                        input logic [OW-1:0] op, input logic [3:0] st,
                        input logic [17:0] ctl, input logic [CW-1:0] cnt,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = r;
        en        = e_i;
        mem_ready = rdy;
        opcode    = op;
        e.st  = st;
        e.ctl = ctl;
        e.cnt = cnt;
        e.nm  = nm;
        q.push_back(e);
    endtask

    task automatic s(input logic e_i, input logic rdy,
                     input logic [OW-1:0] op, input logic [3:0] st,
                     input logic [17:0] ctl, input logic [CW-1:0] cnt,
                     input string nm);
        step(1'b1, e_i, rdy, op, st, ctl, cnt, nm);
    endtask

    task automatic alu_instr(input logic [OW-1:0] op, input logic [17:0] ex,
                             input logic [17:0] wb, input logic [CW-1:0] c);
        s(1, 1, op, S_FETCH, F_RDY, c, "alu_fetch");
        s(1, 0, op, S_DECODE, '0, c, "alu_decode");
        s(1, 0, op, S_EXEC, ex, c, "alu_exec");
        s(1, 0, op, S_ALU_WB, wb, c, "alu_wb");
    endtask

    initial begin
        step(0, 1, 0, O_ADD, S_IDLE, '0, 0, "reset_idle");
        s(1, 0, O_ADD, S_IDLE, '0, 0, "idle");
        alu_instr(O_ADD, '0, RW | RDST, 0);

        s(1, 1, O_LW, S_FETCH, F_RDY, 1, "lw_fetch");
        s(1, 0, O_LW, S_DECODE, '0, 1, "lw_decode");
        s(1, 0, O_LW, S_MADDR, ASRC, 1, "lw_addr");
        repeat (3) s(1, 0, O_LW, S_MACC, IORD | MRD, 1, "lw_wait");
        s(1, 1, O_LW, S_MACC, IORD | MRD, 1, "lw_acc");
        s(1, 0, O_LW, S_MWB, RW | M2R, 1, "lw_wb");

        s(1, 1, O_SW, S_FETCH, F_RDY, 2, "sw_fetch");
        s(1, 0, O_SW, S_DECODE, '0, 2, "sw_decode");
        s(1, 0, O_SW, S_MADDR, ASRC, 2, "sw_addr");
        s(1, 0, O_SW, S_MACC, IORD | MWR, 2, "sw_wait");
        repeat (5) s(0, 1, O_SW, S_MACC, IORD, 2, "sw_stall");
        s(1, 1, O_SW, S_MACC, IORD | MWR, 2, "sw_acc");

        alu_instr(O_ADDI, ASRC, RW | ASRC, 3);
        alu_instr(O_SUB, A_SUB, RW | RDST | A_SUB, 4);
        alu_instr(O_AND, A_AND, RW | RDST | A_AND, 5);
        alu_instr(O_OR, A_OR, RW | RDST | A_OR, 6);

        s(1, 1, O_BEQ, S_FETCH, F_RDY, 7, "beq_fetch");
        s(1, 0, O_BEQ, S_DECODE, '0, 7, "beq_decode");
        s(1, 0, O_BEQ, S_BRANCH, A_SUB | BR | PCC, 7, "beq_branch");

        s(1, 1, O_JMP, S_FETCH, F_RDY, 8, "jmp_fetch");
        s(1, 0, O_JMP, S_DECODE, '0, 8, "jmp_decode");
        s(1, 0, O_JMP, S_JUMP, JMP | PCW, 8, "jmp_jump");

        repeat (7) s(1, 0, O_ADD, S_FETCH, MRD, 9, "fetch_wait");
        s(1, 1, O_ADD, S_FETCH, F_RDY, 9, "fetch_ready_8th");
        s(1, 0, O_ADD, S_DECODE, '0, 9, "late_decode");
        s(1, 0, O_ADD, S_EXEC, '0, 9, "late_exec");
        s(1, 0, O_ADD, S_ALU_WB, RW | RDST, 9, "late_wb");

        for (int i = 10; i < 16; i++) begin
            s(1, 1, O_JMP, S_FETCH, F_RDY, CW'(i), "wrap_fetch");
            s(1, 0, O_JMP, S_DECODE, '0, CW'(i), "wrap_decode");
            s(1, 0, O_JMP, S_JUMP, JMP | PCW, CW'(i), "wrap_jump");
        end

        s(1, 1, O_HALT, S_FETCH, F_RDY, 0, "count_wrapped");
        s(1, 0, O_HALT, S_DECODE, '0, 0, "halt_decode");
        s(1, 0, O_HALT, S_HALT, HLT, 1, "halted");
        s(0, 0, O_HALT, S_HALT, HLT, 1, "halt_stall");
        s(1, 1, O_HALT, S_HALT, HLT, 1, "halt_hold");
        step(0, 1, 1, O_HALT, S_HALT, HLT, 1, "halt_rst_edge");
        s(0, 0, O_ADD, S_IDLE, '0, 0, "halt_rst_idle");
        s(1, 0, O_ADD, S_IDLE, '0, 0, "idle_go");

        s(1, 1, O_ILL_HI, S_FETCH, F_RDY, 0, "ill_hi_fetch");
        s(1, 1, O_ILL_HI, S_DECODE, '0, 0, "ill_hi_decode");
        repeat (2) s(1, 1, O_ILL_HI, S_TRAP, TRP | TC_ILL, 0, "ill_hi_trap");
        step(0, 1, 1, O_ILL_HI, S_TRAP, TRP | TC_ILL, 0, "ill_hi_rst");
        s(1, 0, O_ILL_C, S_IDLE, '0, 0, "ill_hi_idle");

        s(1, 1, O_ILL_C, S_FETCH, F_RDY, 0, "ill_c_fetch");
        s(1, 1, O_ILL_C, S_DECODE, '0, 0, "ill_c_decode");
        s(1, 1, O_ILL_C, S_TRAP, TRP | TC_ILL, 0, "ill_c_trap");
        s(0, 1, O_ILL_C, S_TRAP, TRP | TC_ILL, 0, "ill_c_stall");
        step(0, 1, 1, O_ILL_C, S_TRAP, TRP | TC_ILL, 0, "ill_c_rst");
        s(1, 0, O_ADD, S_IDLE, '0, 0, "ill_c_idle");

        repeat (7) s(1, 0, O_ADD, S_FETCH, MRD, 0, "tmo_wait");
        s(1, 0, O_ADD, S_FETCH, '0, 0, "tmo_8th_no_strobe");
        repeat (2) s(1, 1, O_ADD, S_TRAP, TRP | TC_TMO, 0, "tmo_trap");
        step(0, 1, 1, O_ADD, S_TRAP, TRP | TC_TMO, 0, "tmo_rst");
        s(1, 0, O_ADD, S_IDLE, '0, 0, "tmo_idle");

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
